// File: rtl/rstgen_if.sv
// Reset-sequencer bus: soft-reset handshake, status flags, per-domain resets and acks.
// Master is the requester/domain side; slave is the sequencer.
interface rstgen_if #(
  parameter int NDOM = 2
);
  logic            req;
  logic            busy;
  logic            done;
  logic            timeout;
  logic [NDOM-1:0] rst_dom_n;
  logic [NDOM-1:0] dom_ack;

  modport master (
    output req,
    output dom_ack,
    input  busy,
    input  done,
    input  timeout,
    input  rst_dom_n
  );

  modport slave (
    input  req,
    input  dom_ack,
    output busy,
    output done,
    output timeout,
    output rst_dom_n
  );
endinterface

// File: rtl/rstgen.sv
// rstgen: holds all domains in reset, releases them with a fixed stagger, waits for synced acks.
// Latency: req in IDLE -> resets low next cycle; done 3 cycles after the last ack rises.
// Backpressure: none, req outside IDLE is dropped; RSTGEN_WDT_EN adds the ack watchdog.
module rstgen #(
  parameter int NDOM        = 2,
  parameter int HOLD_CYC    = 16,
  parameter int STAGGER     = 4,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic     clk_sampler,
  input  logic     rst,
  rstgen_if.slave  bus
);

  localparam int M1   = (HOLD_CYC > STAGGER * NDOM) ? HOLD_CYC : STAGGER * NDOM;
  localparam int CMAX = (M1 > ACK_TIMEOUT) ? M1 : ACK_TIMEOUT;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {
    HOLD     = 2'd0,
    RELEASE  = 2'd1,
    WAIT_ACK = 2'd2,
    IDLE     = 2'd3
  } state_t;

  state_t          state, nxt_state;
  logic [CW-1:0]   cnt, nxt_cnt, cnt_inc;
  logic [NDOM-1:0] ack_s1, ack_s2;
  logic [NDOM-1:0] dom_n_q, nxt_dom_n;
  logic            busy_q, nxt_busy;
  logic            done_q, nxt_done;
  logic            timeout_q, nxt_timeout;
  logic            all_ack;

  assign all_ack = &ack_s2;
  // Counter saturates at all-ones so a stuck state can never wrap into a false match.
  assign cnt_inc = (&cnt) ? cnt : cnt + CW'(1);

  always_ff @(posedge clk_sampler) begin
    if (rst) begin
      state     <= HOLD;
      cnt       <= '0;
      ack_s1    <= '0;
      ack_s2    <= '0;
      dom_n_q   <= '0;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state     <= nxt_state;
      cnt       <= nxt_cnt;
      ack_s1    <= bus.dom_ack;
      ack_s2    <= ack_s1;
      dom_n_q   <= nxt_dom_n;
      busy_q    <= nxt_busy;
      done_q    <= nxt_done;
      timeout_q <= nxt_timeout;
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt_inc;
    case (state)
      HOLD: begin
        if (cnt == CW'(HOLD_CYC - 1)) begin
          nxt_state = RELEASE;
          nxt_cnt   = '0;
        end
      end
      RELEASE: begin
        if (cnt == CW'(STAGGER * (NDOM - 1))) begin
          nxt_state = WAIT_ACK;
          nxt_cnt   = '0;
        end
      end
      WAIT_ACK: begin
        if (all_ack) begin
          nxt_state = IDLE;
          nxt_cnt   = '0;
        end
`ifdef RSTGEN_WDT_EN
        else if (cnt == CW'(ACK_TIMEOUT - 1)) begin
          nxt_state = IDLE;
          nxt_cnt   = '0;
        end
`else
        else begin
          nxt_cnt = cnt;
        end
`endif
      end
      IDLE: begin
        nxt_cnt = '0;
        if (bus.req) nxt_state = HOLD;
      end
      default: begin
        nxt_state = HOLD;
        nxt_cnt   = '0;
      end
    endcase
  end

  // Outputs are computed from the next state so every flag lands registered on the transition edge.
  always_comb begin
    nxt_busy  = (nxt_state != IDLE);
    nxt_done  = (state == WAIT_ACK) && all_ack;
    nxt_dom_n = dom_n_q;
    if (nxt_state == HOLD) begin
      nxt_dom_n = '0;
    end else if (nxt_state == RELEASE) begin
      for (int i = 0; i < NDOM; i++) begin
        if (nxt_cnt == CW'(STAGGER * i)) nxt_dom_n[i] = 1'b1;
      end
    end
`ifdef RSTGEN_WDT_EN
    nxt_timeout = timeout_q;
    if ((state == IDLE) && bus.req)
      nxt_timeout = 1'b0;
    else if ((state == WAIT_ACK) && !all_ack && (cnt == CW'(ACK_TIMEOUT - 1)))
      nxt_timeout = 1'b1;
`else
    nxt_timeout = 1'b0;
`endif
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.timeout   = timeout_q;
  assign bus.rst_dom_n = dom_n_q;

endmodule

// File: tb/tb_rstgen.sv
// Directed bench for rstgen: power-up, soft request, mid-release reset, early/glitching acks, stuck ack.
// Domain acks follow rst_dom_n by two cycles in auto mode, or are driven directly in manual mode.
module tb_rstgen;
  localparam int NDOM        = 2;
  localparam int HOLD_CYC    = 16;
  localparam int STAGGER     = 4;
  localparam int ACK_TIMEOUT = 10;

  logic clk_sampler = 1'b0;
  logic rst         = 1'b1;
  logic auto_ack    = 1'b1;
  logic [NDOM-1:0] man_ack = '0;
  logic [NDOM-1:0] ack_d1  = '0;
  logic [NDOM-1:0] ack_d2  = '0;
  int ecnt  = -1;
  int ntot  = 0;
  int nbad  = 0;
  int ndone = 0;

  rstgen_if #(.NDOM(NDOM)) bus ();

  rstgen #(
    .NDOM(NDOM), .HOLD_CYC(HOLD_CYC), .STAGGER(STAGGER), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk_sampler(clk_sampler),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk_sampler = ~clk_sampler;

  assign bus.dom_ack = auto_ack ? ack_d2 : man_ack;

  always @(posedge clk_sampler) begin
    ack_d1 <= bus.rst_dom_n;
    ack_d2 <= ack_d1;
    if (bus.done) ndone <= ndone + 1;
  end

  task automatic tick();
    @(posedge clk_sampler);
    #1;
    ecnt++;
  endtask

  task automatic go(input int n);
    while (ecnt < n) tick();
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    ntot++;
    assert (obs === exp) else begin
      nbad++;
      $error("FAIL %s @%0d got=%0d exp=%0d", tag, ecnt, obs, exp);
    end
  endtask

  initial begin
    bus.req = 1'b0;
    tick();
    rst = 1'b0;
    chk("rst_dom_n_reset", int'(bus.rst_dom_n), 0);
    chk("busy_reset",      int'(bus.busy), 1);
    chk("done_reset",      int'(bus.done), 0);
    chk("timeout_reset",   int'(bus.timeout), 0);

    // power-up sequence
    go(15); chk("pu_hold_end", int'(bus.rst_dom_n), 0);
    go(16); chk("pu_rel0", int'(bus.rst_dom_n), 1);
    go(19); chk("pu_rel0_only", int'(bus.rst_dom_n), 1);
    go(20); chk("pu_rel1", int'(bus.rst_dom_n), 3);
    go(24); chk("pu_done_early", int'(bus.done), 0); chk("pu_busy_wait", int'(bus.busy), 1);
    go(25); chk("pu_done", int'(bus.done), 1); chk("pu_busy_fall", int'(bus.busy), 0);
    go(26); chk("pu_done_pulse", int'(bus.done), 0); chk("pu_idle_busy", int'(bus.busy), 0);

    // soft request with an ignored second request
    bus.req = 1'b1; go(27); bus.req = 1'b0;
    chk("sr_hold", int'(bus.rst_dom_n), 0); chk("sr_busy", int'(bus.busy), 1);
    go(30); bus.req = 1'b1; go(31); bus.req = 1'b0;
    go(43); chk("sr_rel0", int'(bus.rst_dom_n), 1);
    go(47); chk("sr_rel1", int'(bus.rst_dom_n), 3);
    go(51); chk("sr_done_early", int'(bus.done), 0); chk("sr_busy_wait", int'(bus.busy), 1);
    go(52); chk("sr_done", int'(bus.done), 1); chk("sr_busy_fall", int'(bus.busy), 0);
    go(53); chk("sr_done_pulse", int'(bus.done), 0); chk("sr_ndone", ndone, 2);

    // rst mid-release
    bus.req = 1'b1; go(54); bus.req = 1'b0;
    chk("mr_hold", int'(bus.rst_dom_n), 0);
    go(71); chk("mr_partial", int'(bus.rst_dom_n), 1);
    rst = 1'b1; go(72); rst = 1'b0;
    chk("mr_reheld", int'(bus.rst_dom_n), 0); chk("mr_busy", int'(bus.busy), 1);
    chk("mr_no_done", int'(bus.done), 0);
    go(88); chk("mr_rel0", int'(bus.rst_dom_n), 1);
    go(91); chk("mr_rel0_only", int'(bus.rst_dom_n), 1);
    go(92); chk("mr_rel1", int'(bus.rst_dom_n), 3);
    go(96); chk("mr_done_early", int'(bus.done), 0);
    go(97); chk("mr_done", int'(bus.done), 1); chk("mr_ndone", ndone, 2);

    // acks already high before WAIT_ACK
    auto_ack = 1'b0; man_ack = 2'b11;
    bus.req = 1'b1; go(98); bus.req = 1'b0;
    chk("ea_hold", int'(bus.rst_dom_n), 0);
    go(119); chk("ea_wait_done", int'(bus.done), 0); chk("ea_wait_busy", int'(bus.busy), 1);
    chk("ea_released", int'(bus.rst_dom_n), 3);
    go(120); chk("ea_done", int'(bus.done), 1); chk("ea_busy_fall", int'(bus.busy), 0);

    // ack[1] low for 3 cycles around WAIT_ACK entry
    go(121); bus.req = 1'b1; go(122); bus.req = 1'b0;
    chk("gl_hold", int'(bus.rst_dom_n), 0);
    go(141); man_ack = 2'b01;
    go(143); chk("gl_released", int'(bus.rst_dom_n), 3);
    go(144); man_ack = 2'b11;
    chk("gl_no_done", int'(bus.done), 0); chk("gl_busy", int'(bus.busy), 1);
    go(146); chk("gl_still_wait", int'(bus.done), 0); chk("gl_no_restart", int'(bus.rst_dom_n), 3);
    go(147); chk("gl_done", int'(bus.done), 1); chk("gl_busy_fall", int'(bus.busy), 0);
    chk("gl_ndone", ndone, 4);

    // ack[1] stuck low
    man_ack = 2'b01; bus.req = 1'b1; go(148); bus.req = 1'b0;
    chk("st_busy", int'(bus.busy), 1);
`ifdef RSTGEN_WDT_EN
    go(178); chk("wd_pre_to", int'(bus.timeout), 0); chk("wd_pre_busy", int'(bus.busy), 1);
    go(179); chk("wd_timeout", int'(bus.timeout), 1); chk("wd_busy", int'(bus.busy), 0);
    chk("wd_no_done", int'(bus.done), 0); chk("wd_released", int'(bus.rst_dom_n), 3);
    go(181); chk("wd_sticky", int'(bus.timeout), 1);
    bus.req = 1'b1; go(182); bus.req = 1'b0;
    chk("wd_clear", int'(bus.timeout), 0); chk("wd_rehold", int'(bus.rst_dom_n), 0);
`else
    go(1169); chk("nw_busy", int'(bus.busy), 1); chk("nw_timeout", int'(bus.timeout), 0);
    chk("nw_done", int'(bus.done), 0); chk("nw_released", int'(bus.rst_dom_n), 3);
`endif
    chk("final_ndone", ndone, 5);

    $display("test done: total=%0d bad=%0d", ntot, nbad);
    $finish;
  end
endmodule

// File: doc/rstgen.md
# rstgen

Reset sequencer in the sampler clock domain. Drives the active-low per-domain reset lines that the downstream reset synchronizers consume. Holds all domains in reset after power-up or on a soft-reset request, then releases them one by one with a fixed stagger. Waits for every domain to acknowledge that it is out of reset, then reports completion to the requester.

## Interface
Parameters:
- NDOM, 2, number of reset domains driven (1..8)
- HOLD_CYC, 16, cycles all domains are held in reset (>= 4)
- STAGGER, 4, cycles between consecutive domain releases (>= 1)
- ACK_TIMEOUT, 255, cycles allowed in WAIT_ACK before timeout (used only with RSTGEN_WDT_EN)

Ports:
- clk_sampler  in  1  sampler clock; all logic on posedge
- rst  in  1  one clock, synchronous, active-high reset
- req  in  1  soft-reset request, level, sampled only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the sequence completes with all acks seen
- timeout  out  1  sticky ack-timeout flag (tied 0 without RSTGEN_WDT_EN)
- rst_dom_n  out  NDOM  active-low reset per domain, registered
- dom_ack  in  NDOM  asynchronous; high when domain i reports its synchronized reset deasserted

## Operation
- Reset values (cycle after rst sampled high): rst_dom_n=0, busy=1, done=0, timeout=0, state=HOLD, counter=0. Power-up therefore runs a full sequence with no request.
- dom_ack passes through a 2-flop synchronizer per bit, also cleared by rst. FSM uses only the synchronized acks.
- States:
  - HOLD: all rst_dom_n=0. Counter runs 0..HOLD_CYC-1, then go to RELEASE with counter=0.
  - RELEASE: rst_dom_n[i] goes high when counter reaches STAGGER*i. Once set, a bit stays high until the next HOLD. After counter = STAGGER*(NDOM-1), go to WAIT_ACK.
  - WAIT_ACK: when all synced acks are 1, pulse done and go to IDLE.
  - IDLE: busy=0. req=1 goes to HOLD and clears timeout.
- req outside IDLE is ignored, not queued. Holding req high produces back-to-back sequences.
- Counter width is $clog2(max(HOLD_CYC, STAGGER*NDOM, ACK_TIMEOUT)+1). It saturates and never wraps.
- Acks are ignored outside WAIT_ACK. HOLD_CYC >= 4 guarantees downstream acks have dropped before release.
- rst mid-sequence: on the next edge, go to HOLD with counter=0 and all rst_dom_n=0. No done pulse.
- A domain ack dropping during WAIT_ACK simply delays done. It never restarts the sequence.

## Timing
- req high in IDLE at edge k: busy=1 and rst_dom_n=0 from k+1.
- rst_dom_n[0] rises at k+1+HOLD_CYC.
- rst_dom_n[i] rises at k+1+HOLD_CYC+STAGGER*i.
- dom_ack all high at edge m (m after last release): synced at m+2, done=1 for cycle m+3, busy=0 from m+3.
- Acks already high before entering WAIT_ACK: done is asserted on the first WAIT_ACK cycle.
- done and busy are registered outputs with no combinational paths from inputs.

## Configuration
- RSTGEN_WDT_EN defined: the counter runs in WAIT_ACK.
  - If it reaches ACK_TIMEOUT with acks incomplete: timeout=1 (sticky), go to IDLE, no done pulse.
  - Domain resets stay released.
  - timeout clears only on rst or on an accepted req.
- RSTGEN_WDT_EN undefined: WAIT_ACK waits indefinitely and timeout is constant 0. Port list is unchanged.

## Test plan
- Power-up: rst 1 cycle, NDOM=2, HOLD_CYC=16, STAGGER=4, acks follow rst_dom_n after 2 cycles -> rst_dom_n[0] rises at cycle 17, rst_dom_n[1] at cycle 21, done pulses once, busy falls in the same cycle.
- Soft request: req pulse in IDLE -> rst_dom_n=2'b00 next cycle; full sequence repeats; second req issued while busy is ignored (exactly one done).
- rst asserted mid-RELEASE (rst_dom_n=2'b01) -> next cycle rst_dom_n=2'b00 and busy=1; new sequence times from that point; no done.
- Ack glitch: dom_ack[1] drops for 3 cycles in WAIT_ACK -> done delayed by 3 cycles, no restart.
- RSTGEN_WDT_EN, ACK_TIMEOUT=10, dom_ack[1] stuck 0 -> timeout=1 after 10 WAIT_ACK cycles, busy=0, no done; next req clears timeout.
- Without RSTGEN_WDT_EN, same stimulus -> FSM stays in WAIT_ACK for 1000 cycles, timeout=0, busy=1.
